trace_runner: RTL
=================

# trace_runner

Synthesizable run controller and trace collector for the single-cycle `yChip` core. It boots the core by presenting an entry point with a one-cycle interrupt pulse. It then samples the core's per-instruction outputs (`ins`, `rd2`, `wb`) for a programmed number of instructions and buffers them for a host that drains the records with a valid/ready handshake. This lets a program run be captured in hardware instead of printed cycle by cycle.

## Interface
Parameters:
- `DEPTH`, 16: trace FIFO entries, power of two, ≥2
- `CNTW`, 16: width of instruction-count fields

Ports:
- `clk`  in  1: single clock, shared with `yChip`
- `rst_n`  in  1: asynchronous, active-low reset
- `start`  in  1: begin a run; sampled only in IDLE
- `entry_in`  in  32: program entry address, latched on accepted `start`
- `n_ins`  in  CNTW: instructions to capture, latched on accepted `start`
- `ins`  in  32: core's current instruction
- `rd2`  in  32: core's register-file read port 2
- `wb`  in  32: core's write-back value
- `entry_point`  out  32: to `yChip` entryPoint
- `intr`  out  1: to `yChip` INT
- `rec_valid`  out  1: head record available
- `rec_ready`  in  1: host accepts head record
- `rec_data`  out  96: `{ins, rd2, wb}` of head record
- `busy`  out  1: state is BOOT or RUN
- `done`  out  1: high in DONE
- `overflow`  out  1: sticky; a record was dropped because the FIFO was full
- `captured`  out  CNTW: instructions sampled so far in this run

## Operation
- States: IDLE, BOOT, RUN, DONE.
- IDLE behaviour:
  - With `start=1`, latch `entry_in` and `n_ins`, then go to BOOT.
  - If `n_ins=0`, go directly to DONE and never assert `intr`.
- BOOT behaviour:
  - `intr=1` for exactly one cycle.
  - `entry_point` holds the latched address from IDLE exit until the next accepted `start`.
  - Clear `captured` and `overflow`, then go to RUN.
- RUN behaviour:
  - Each cycle, sample `{ins, rd2, wb}` and increment `captured`.
  - Push the sample if the FIFO is not full. Otherwise drop it and set `overflow`.
  - When the increment makes `captured == n_ins`, go to DONE.
- DONE behaviour:
  - Hold `captured`.
  - The FIFO continues to drain.
  - Return to IDLE when `start=0`. This requires `start` to drop before a new run begins.
- FIFO:
  - A pop occurs when `rec_valid && rec_ready`.
  - Push and pop in the same cycle are both legal, including when the FIFO is full. A pop on a full FIFO frees a slot for that cycle's push, so nothing is dropped.
  - `rec_data` is stable while `rec_valid && !rec_ready`.
  - The FIFO is cleared only by reset. Records from a previous run remain and are drained first.
- `start` during BOOT or RUN is ignored.
- `captured` saturates at `n_ins`.

## Timing
- Reset values, all asynchronous:
  - state IDLE
  - `entry_point=0`, `intr=0`
  - `rec_valid=0`, `rec_data=0`
  - `busy=0`, `done=0`, `overflow=0`, `captured=0`
  - FIFO empty
- Sequence from `start` (edge numbers are relative to the edge that samples `start` high):
  - **Edge 0:** `start` sampled high; enter BOOT.
  - **Cycle after edge 0:** `intr=1`, so the core fetches `entry_point` at edge 1.
  - **Edge 2:** first RUN sample, which is the instruction at the entry point.
- A run of N instructions leaves RUN after N RUN edges. `busy` is high for N+1 cycles.
- Push-to-`rec_valid` latency is 1 cycle, since the FIFO head is registered.
- Reset asserted mid-run aborts immediately. `intr` drops asynchronously.

## Structure
- Package `trace_pkg`:
  - state enum (IDLE/BOOT/RUN/DONE)
  - `REC_W=96` and field offsets `INS_LSB=64`, `RD2_LSB=32`, `WB_LSB=0`
- Sub-module `trace_fifo`:
  - parameterized by `DEPTH` and `REC_W`
  - `clk`/`rst_n`, push/full, pop/empty, registered head
  - implements the simultaneous push/pop-when-full rule
- `trace_runner` contains the FSM, latches and counter, and instantiates `trace_fifo`.

## Test plan
- Basic run with a `yChip` model:
  - Stimulus: `entry_in=32'h28`, `n_ins=43`, `rec_ready=1`.
  - Required: `intr` high for exactly one cycle; first record's `ins` equals the word at address 0x28; 43 records; `done=1`; `captured=43`; `overflow=0`.
- Overflow:
  - Stimulus: `DEPTH=16`, `n_ins=20`, `rec_ready=0` throughout.
  - Required: 16 records held; `overflow=1`; `captured=20`. After raising `rec_ready`, exactly 16 records drain in order.
- Full-FIFO push+pop:
  - Stimulus: fill the FIFO, then pulse `rec_ready` for a single cycle while RUN is pushing.
  - Required: no drop; `overflow` stays 0 for that cycle.
- Zero-length run:
  - Stimulus: `n_ins=0`.
  - Required: IDLE→DONE; `intr` never asserted; `captured=0`.
- Reset and restart:
  - Stimulus: assert `rst_n=0` at RUN cycle 5 of a 10-instruction run.
  - Required: all outputs return to reset values within the same cycle; a subsequent start runs normally.
- `start` handling:
  - Stimulus: `start` re-pulsed during RUN; `start` held high into DONE.
  - Required: the RUN pulse is ignored and `captured` is unaffected; the FSM stays in DONE until `start=0`.

Source files
------------

// File: rtl/trace_runner_pkg.sv
// Shared types for the yChip run controller and trace collector.
// Record layout is {ins, rd2, wb} with ins in the top word.
package trace_pkg;

    localparam int REC_W   = 96;
    localparam int INS_LSB = 64;
    localparam int RD2_LSB = 32;
    localparam int WB_LSB  = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BOOT = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] rd2;
        logic [31:0] wb;
    } rec_t;

endpackage

// File: rtl/trace_runner_if.sv
// Trace record stream from the collector to the host.
// valid/ready handshake; a beat transfers when both are high.
interface trace_runner_if;
    import trace_pkg::*;

    logic rec_valid;
    logic rec_ready;
    rec_t rec_data;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);

endinterface

// File: rtl/trace_fifo.sv
// Trace record FIFO with a register-array head.
// Latency: push to non-empty is 1 cycle.
// Backpressure: a push on full is accepted only if a pop happens in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int REC_W = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [REC_W-1:0] push_dat,
    output logic             full,
    input  logic             pop,
    output logic [REC_W-1:0] pop_dat,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot this push lands in
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/trace_runner.sv
// Boots yChip at a programmed entry point and captures n_ins per-instruction records.
// Latency: first record sampled two edges after start; record visible one cycle after push.
// Backpressure: host stalls via rec_ready; records arriving on a full FIFO are dropped and flagged.
module trace_runner
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [31:0]     entry_in,
    input  logic [CNTW-1:0] n_ins,
    input  logic [31:0]     ins,
    input  logic [31:0]     rd2,
    input  logic [31:0]     wb,
    output logic [31:0]     entry_point,
    output logic            intr,
    trace_runner_if.master  rec,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [CNTW-1:0] captured
);

    state_t          state;
    logic [CNTW-1:0] n_lat;
    logic [CNTW-1:0] cap_nxt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    rec_t            sample;

    assign sample.ins = ins;
    assign sample.rd2 = rd2;
    assign sample.wb  = wb;

    assign push    = (state == ST_RUN);
    assign pop     = rec.rec_valid && rec.rec_ready;
    assign cap_nxt = captured + CNTW'(1);

    // decoded from the registered state so the async reset drops them at once
    assign intr = (state == ST_BOOT);
    assign busy = (state == ST_BOOT) || (state == ST_RUN);
    assign done = (state == ST_DONE);

    assign rec.rec_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            entry_point <= '0;
            n_lat       <= '0;
            captured    <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        entry_point <= entry_in;
                        n_lat       <= n_ins;
                        captured    <= '0;
                        overflow    <= 1'b0;
                        state       <= (n_ins == '0) ? ST_DONE : ST_BOOT;
                    end
                end
                ST_BOOT: begin
                    captured <= '0;
                    overflow <= 1'b0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (fifo_full && !pop) begin
                        overflow <= 1'b1;
                    end
                    if (captured != n_lat) begin
                        captured <= cap_nxt;
                        if (cap_nxt == n_lat) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (sample),
        .full     (fifo_full),
        .pop      (pop),
        .pop_dat  (rec.rec_data),
        .empty    (fifo_empty)
    );

endmodule
